// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, no-write-allocate L1 controller in front of cache_block.
// Latency: read hit responds 2 cycles after accept; a miss or write responds 1 cycle after mem_ack.
// Backpressure: req_ready is low from LOOKUP until RESP ends, so at most one request is outstanding.
//
// Optional feature macro: CACHE_STATS_EN (adds the hit_cnt/miss_cnt saturating counters).
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   req_valid/we/addr/wdata     core request, accepted when req_ready is high
//   req_ready                   high only in IDLE
//   resp_valid, resp_rdata      one-cycle completion pulse and read data (0 for writes)
//   cb_index/cb_we/cb_din       drive the cache_block data array
//   cb_dout                     combinational read data of cache_block at cb_index
//   mem_req/we/addr/wdata       single-word memory access, held until mem_ack
//   mem_ack, mem_rdata          memory completion and refill data (same cycle)
//   hit_cnt, miss_cnt           lookup statistics (CACHE_STATS_EN only)
module cache_ctrl #(
  parameter int NUM_OF_ENTRY = 1024,
  parameter int ENTRY_WIDTH  = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 2,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    req_ready,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic [ENTRY_WIDTH-1:0]  cb_index,
  output logic                    cb_we,
  output logic [DATA_WIDTH-1:0]   cb_din,
  input  logic [DATA_WIDTH-1:0]   cb_dout,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ack,
`ifdef CACHE_STATS_EN
  output logic [15:0]             hit_cnt,
  output logic [15:0]             miss_cnt,
`endif
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int TAG_WIDTH = ADDR_WIDTH - ENTRY_WIDTH - OFFSET_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    WRITE_MEM,
    RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [ENTRY_WIDTH-1:0]  idx_q, idx_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [NUM_OF_ENTRY-1:0] valid_q;
  logic [TAG_WIDTH-1:0]    tag_arr_q [NUM_OF_ENTRY];

  logic [TAG_WIDTH-1:0]    req_tag;
  logic [ENTRY_WIDTH-1:0]  req_idx;
  logic                    hit;
  logic                    fill_en;

  logic                    req_ready_c, resp_valid_c, cb_we_c, mem_req_c, mem_we_c;
  logic [ENTRY_WIDTH-1:0]  cb_index_c;
  logic [DATA_WIDTH-1:0]   cb_din_c, mem_wdata_c;

  // The byte offset plays no part in lookup; memory sees word-aligned addresses.
  logic unused_offset;
  assign unused_offset = ^req_addr[OFFSET_WIDTH-1:0];

  assign req_tag = req_addr[ADDR_WIDTH-1:ENTRY_WIDTH+OFFSET_WIDTH];
  assign req_idx = req_addr[ENTRY_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
  assign hit     = valid_q[idx_q] && (tag_arr_q[idx_q] == tag_q);

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    fill_en      = 1'b0;
    req_ready_c  = 1'b0;
    resp_valid_c = 1'b0;
    cb_index_c   = idx_q;
    cb_we_c      = 1'b0;
    cb_din_c     = '0;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    mem_wdata_c  = '0;
    case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        cb_index_c  = req_idx;
        if (req_valid) begin
          tag_d   = req_tag;
          idx_d   = req_idx;
          we_d    = req_we;
          wdata_d = req_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!we_q) begin
          if (hit) begin
            rdata_d = cb_dout;
            state_d = RESP;
          end else begin
            state_d = REFILL;
          end
        end else begin
          // Write-through: update the array only when the line is present.
          if (hit) begin
            cb_we_c  = 1'b1;
            cb_din_c = wdata_q;
          end
          state_d = WRITE_MEM;
        end
      end
      REFILL: begin
        mem_req_c = 1'b1;
        if (mem_ack) begin
          cb_we_c  = 1'b1;
          cb_din_c = mem_rdata;
          fill_en  = 1'b1;
          rdata_d  = mem_rdata;
          state_d  = RESP;
        end
      end
      WRITE_MEM: begin
        mem_req_c   = 1'b1;
        mem_we_c    = 1'b1;
        mem_wdata_c = wdata_q;
        if (mem_ack) begin
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid_c = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tag_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      if (fill_en) valid_q[idx_q] <= 1'b1;
    end
  end

  // Tags need no reset: a stale tag is never consulted while its valid bit is clear.
  always_ff @(posedge clk) begin
    if (!rst && fill_en) tag_arr_q[idx_q] <= tag_q;
  end

  // Outputs are forced low while rst is high so an access cut short by reset
  // cannot write the array, signal completion or keep the memory request up.
  assign req_ready  = !rst && req_ready_c;
  assign resp_valid = !rst && resp_valid_c;
  assign resp_rdata = rst ? '0 : rdata_q;
  assign cb_index   = rst ? '0 : cb_index_c;
  assign cb_we      = !rst && cb_we_c;
  assign cb_din     = rst ? '0 : cb_din_c;
  assign mem_req    = !rst && mem_req_c;
  assign mem_we     = !rst && mem_we_c;
  assign mem_addr   = rst ? '0 : {tag_q, idx_q, {OFFSET_WIDTH{1'b0}}};
  assign mem_wdata  = rst ? '0 : mem_wdata_c;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_cnt  = rst ? '0 : hit_cnt_q;
  assign miss_cnt = rst ? '0 : miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: drives cache_ctrl against a cache_block array model and a latency-programmable memory.
// Latency: memory ack delay set per scenario through mem_lat.
// Backpressure: none toward the DUT; every response is consumed immediately.
module tb_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, cb_we, mem_req, mem_we, mem_ack;
  logic [31:0] resp_rdata, cb_din, cb_dout, mem_addr, mem_wdata, mem_rdata;
  logic [9:0]  cb_index;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  cache_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .cb_index(cb_index), .cb_we(cb_we), .cb_din(cb_din), .cb_dout(cb_dout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
`ifdef CACHE_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // cache_block model: combinational read, write on the rising edge.
  logic [31:0] cb_mem [1024];
  initial for (int i = 0; i < 1024; i++) cb_mem[i] = '0;
  always @(posedge clk) if (cb_we) cb_mem[cb_index] <= cb_din;
  assign cb_dout = cb_mem[cb_index];

  // Memory model: acks after mem_lat wait cycles; data is garbage outside the ack cycle.
  int          mem_lat = 0;
  int          mwait = 0;
  logic [31:0] mem_rdata_v = '0;
  always @(posedge clk) if (!mem_req || mem_ack) mwait <= 0; else mwait <= mwait + 1;
  assign mem_ack   = mem_req && (mwait == mem_lat);
  assign mem_rdata = mem_ack ? mem_rdata_v : 32'hDEAD_0BAD;

  int errors = 0;
  int checks = 0;

  // Scoreboard and event monitor, sampled on the falling edge.
  logic [31:0] exp_q [$];
  logic [31:0] exp_val;
  int resp_cnt = 0, resp_cyc = 0;
  int cbwe_cnt = 0, cbwe_cyc = 0;
  logic [9:0]  last_cb_idx = '0;
  logic [31:0] last_cb_din = '0;
  int memreq_cycles = 0, memreq_start = 0, mem_txn = 0, ack_cyc = 0;
  logic mem_req_prev = 1'b0;
  logic last_mem_we = 1'b0;
  logic [31:0] last_mem_addr = '0, last_mem_wdata = '0;

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      resp_cnt++;
      resp_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got resp rdata=%h, required no response", resp_rdata);
      end else begin
        exp_val = exp_q.pop_front();
        if (resp_rdata !== exp_val) begin
          errors++;
          $display("FAIL resp_rdata: got %h, required %h", resp_rdata, exp_val);
        end
      end
    end
    if (cb_we === 1'b1) begin
      cbwe_cnt++;
      cbwe_cyc = cyc;
      last_cb_idx = cb_index;
      last_cb_din = cb_din;
    end
    if (mem_req === 1'b1 && !mem_req_prev) memreq_start = cyc;
    mem_req_prev = (mem_req === 1'b1);
    if (mem_req === 1'b1) memreq_cycles++;
    if (mem_req === 1'b1 && mem_ack === 1'b1) begin
      mem_txn++;
      ack_cyc = cyc;
      last_mem_we = mem_we;
      last_mem_addr = mem_addr;
      last_mem_wdata = mem_wdata;
    end
  end

  task automatic issue_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp, output int t);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%b, required 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    exp_q.push_back(exp);
    t = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_wdata = '0;
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp, output int t);
    int s, n;
    s = resp_cnt;
    issue_req(we, addr, wd, exp, t);
    n = 0;
    @(negedge clk); #1;
    while (resp_cnt == s && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (resp_cnt == s) begin
      errors++;
      $display("FAIL resp_timeout: addr=%h got no resp_valid, required one", addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_addr = 32'h0000_0008;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if ({req_ready, resp_valid, cb_we, mem_req, mem_we} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b, required 00000", {req_ready, resp_valid, cb_we, mem_req, mem_we}); end
    checks++; if (cb_index !== 10'd0) begin errors++; $display("FAIL reset_cb_index: got %0d, required 0", cb_index); end
    checks++; if ({cb_din, resp_rdata, mem_addr, mem_wdata} !== 128'd0) begin errors++; $display("FAIL reset_data: got %h, required 0", {cb_din, resp_rdata, mem_addr, mem_wdata}); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", req_ready); end
    checks++; if (cb_index !== 10'd2) begin errors++; $display("FAIL idle_cb_index: got %0d, required 2", cb_index); end
  endtask

  task automatic test_read_miss();
    int t, w0, m0;
    mem_lat = 2; mem_rdata_v = 32'h0000_0FF0;
    w0 = cbwe_cnt; m0 = mem_txn;
    do_req(1'b0, 32'h0000_0008, 32'h0, 32'h0000_0FF0, t);
    checks++; if (mem_txn - m0 !== 1) begin errors++; $display("FAIL miss_mem_txn: got %0d, required 1", mem_txn - m0); end
    checks++; if ({last_mem_we, last_mem_addr} !== {1'b0, 32'h0000_0008}) begin errors++; $display("FAIL miss_mem_req: got we=%b addr=%h, required we=0 addr=00000008", last_mem_we, last_mem_addr); end
    checks++; if (cbwe_cnt - w0 !== 1 || cbwe_cyc !== ack_cyc) begin errors++; $display("FAIL miss_cb_we: got %0d pulses at %0d, required 1 at %0d", cbwe_cnt - w0, cbwe_cyc, ack_cyc); end
    checks++; if ({last_cb_idx, last_cb_din} !== {10'd2, 32'h0000_0FF0}) begin errors++; $display("FAIL miss_cb_write: got idx=%0d din=%h, required idx=2 din=00000ff0", last_cb_idx, last_cb_din); end
    checks++; if (resp_cyc !== t + 5) begin errors++; $display("FAIL miss_latency: got resp at T+%0d, required T+5", resp_cyc - t); end
`ifdef CACHE_STATS_EN
    checks++; if (miss_cnt !== 16'd1) begin errors++; $display("FAIL stats_miss: got %0d, required 1", miss_cnt); end
`endif
  endtask

  task automatic test_read_hit();
    int t, w0, q0;
    w0 = cbwe_cnt; q0 = memreq_cycles;
    do_req(1'b0, 32'h0000_0008, 32'h0, 32'h0000_0FF0, t);
    checks++; if (resp_cyc !== t + 2) begin errors++; $display("FAIL hit_latency: got resp at T+%0d, required T+2", resp_cyc - t); end
    checks++; if (memreq_cycles - q0 !== 0 || cbwe_cnt - w0 !== 0) begin errors++; $display("FAIL hit_side_effects: got mem_req cycles=%0d cb_we=%0d, required 0 and 0", memreq_cycles - q0, cbwe_cnt - w0); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ready_in_resp: got %b, required 0", req_ready); end
    @(negedge clk); #1;
    checks++; if ({req_ready, resp_valid} !== 2'b10) begin errors++; $display("FAIL ready_after_resp: got ready=%b resp_valid=%b, required 1 0", req_ready, resp_valid); end
`ifdef CACHE_STATS_EN
    checks++; if (hit_cnt !== 16'd1) begin errors++; $display("FAIL stats_hit: got %0d, required 1", hit_cnt); end
`endif
  endtask

  task automatic test_write_hit();
    int t, w0, m0, q0;
    mem_lat = 1;
    w0 = cbwe_cnt; m0 = mem_txn;
    do_req(1'b1, 32'h0000_0008, 32'h0000_A5A5, 32'h0, t);
    checks++; if (cbwe_cnt - w0 !== 1 || cbwe_cyc !== t + 1) begin errors++; $display("FAIL whit_cb_we: got %0d pulses at T+%0d, required 1 at T+1", cbwe_cnt - w0, cbwe_cyc - t); end
    checks++; if ({last_cb_idx, last_cb_din} !== {10'd2, 32'h0000_A5A5}) begin errors++; $display("FAIL whit_cb_write: got idx=%0d din=%h, required idx=2 din=0000a5a5", last_cb_idx, last_cb_din); end
    checks++; if (mem_txn - m0 !== 1 || memreq_start !== t + 2) begin errors++; $display("FAIL whit_mem_start: got %0d txns from T+%0d, required 1 from T+2", mem_txn - m0, memreq_start - t); end
    checks++; if ({last_mem_we, last_mem_addr, last_mem_wdata} !== {1'b1, 32'h0000_0008, 32'h0000_A5A5}) begin errors++; $display("FAIL whit_mem_write: got we=%b addr=%h data=%h, required we=1 addr=00000008 data=0000a5a5", last_mem_we, last_mem_addr, last_mem_wdata); end
    checks++; if (resp_cyc !== ack_cyc + 1) begin errors++; $display("FAIL whit_resp_timing: got resp at %0d, required %0d", resp_cyc, ack_cyc + 1); end
    q0 = memreq_cycles;
    do_req(1'b0, 32'h0000_000A, 32'h0, 32'h0000_A5A5, t);
    checks++; if (memreq_cycles - q0 !== 0) begin errors++; $display("FAIL whit_readback_mem: got %0d mem_req cycles, required 0", memreq_cycles - q0); end
  endtask

  task automatic test_write_miss();
    int t, w0, m0, q0;
    mem_lat = 0;
    w0 = cbwe_cnt; m0 = mem_txn;
    do_req(1'b1, 32'h0001_000B, 32'h0000_1234, 32'h0, t);
    checks++; if (cbwe_cnt - w0 !== 0) begin errors++; $display("FAIL wmiss_cb_we: got %0d pulses, required 0", cbwe_cnt - w0); end
    checks++; if (mem_txn - m0 !== 1) begin errors++; $display("FAIL wmiss_mem_txn: got %0d, required 1", mem_txn - m0); end
    checks++; if ({last_mem_we, last_mem_addr, last_mem_wdata} !== {1'b1, 32'h0001_0008, 32'h0000_1234}) begin errors++; $display("FAIL wmiss_mem_write: got we=%b addr=%h data=%h, required we=1 addr=00010008 data=00001234", last_mem_we, last_mem_addr, last_mem_wdata); end
    q0 = memreq_cycles;
    do_req(1'b0, 32'h0000_0008, 32'h0, 32'h0000_A5A5, t);
    checks++; if (memreq_cycles - q0 !== 0) begin errors++; $display("FAIL wmiss_still_hit: got %0d mem_req cycles, required 0", memreq_cycles - q0); end
  endtask

  task automatic test_conflict();
    int t, m0;
    mem_lat = 0; mem_rdata_v = 32'h0000_BEEF;
    m0 = mem_txn;
    do_req(1'b0, 32'h0001_0008, 32'h0, 32'h0000_BEEF, t);
    checks++; if (mem_txn - m0 !== 1 || resp_cyc !== t + 3) begin errors++; $display("FAIL conflict_miss: got %0d txns, resp at T+%0d, required 1 txn at T+3", mem_txn - m0, resp_cyc - t); end
    checks++; if ({last_cb_idx, last_cb_din} !== {10'd2, 32'h0000_BEEF}) begin errors++; $display("FAIL conflict_fill: got idx=%0d din=%h, required idx=2 din=0000beef", last_cb_idx, last_cb_din); end
    mem_rdata_v = 32'h0000_1111;
    m0 = mem_txn;
    do_req(1'b0, 32'h0000_0008, 32'h0, 32'h0000_1111, t);
    checks++; if (mem_txn - m0 !== 1) begin errors++; $display("FAIL conflict_evicted: got %0d txns, required 1", mem_txn - m0); end
  endtask

  task automatic test_back_to_back();
    int t, q0, idx;
    logic [31:0] addr, data;
    for (int i = 0; i < 4; i++) begin
      idx = $urandom_range(32, 1023);
      addr = ((32'h100 + i) << 12) | (idx << 2);
      data = $urandom;
      mem_lat = i % 3; mem_rdata_v = data;
      do_req(1'b0, addr, 32'h0, data, t);
      q0 = memreq_cycles;
      do_req(1'b0, addr, 32'h0, data, t);
      checks++; if (memreq_cycles - q0 !== 0 || resp_cyc !== t + 2) begin errors++; $display("FAIL b2b_hit: addr=%h got mem_req cycles=%0d resp at T+%0d, required 0 at T+2", addr, memreq_cycles - q0, resp_cyc - t); end
    end
  endtask

  task automatic test_reset_mid_refill();
    int t, r0, w0, m0;
    mem_lat = 30;
    r0 = resp_cnt; w0 = cbwe_cnt; m0 = mem_txn;
    issue_req(1'b0, 32'h0000_0040, 32'h0, 32'h0, t);
    repeat (3) begin @(negedge clk); #1; end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_refill_waiting: got mem_req=%b, required 1", mem_req); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    checks++; if ({mem_req, cb_we, resp_valid} !== 3'b000) begin errors++; $display("FAIL mid_refill_abort: got mem_req/cb_we/resp_valid=%b, required 000", {mem_req, cb_we, resp_valid}); end
    rst = 1'b0;
    exp_q.delete();
`ifdef CACHE_STATS_EN
    checks++; if ({hit_cnt, miss_cnt} !== 32'd0) begin errors++; $display("FAIL stats_cleared: got hit=%0d miss=%0d, required 0 0", hit_cnt, miss_cnt); end
`endif
    repeat (40) @(negedge clk);
    checks++; if (resp_cnt - r0 !== 0 || cbwe_cnt - w0 !== 0 || mem_txn - m0 !== 0) begin errors++; $display("FAIL mid_refill_quiet: got resp=%0d cb_we=%0d txn=%0d, required 0 0 0", resp_cnt - r0, cbwe_cnt - w0, mem_txn - m0); end
    mem_lat = 1; mem_rdata_v = 32'h0000_2222;
    m0 = mem_txn;
    do_req(1'b0, 32'h0000_0008, 32'h0, 32'h0000_2222, t);
    checks++; if (mem_txn - m0 !== 1) begin errors++; $display("FAIL valid_cleared: got %0d txns, required 1", mem_txn - m0); end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_back_to_back();
    test_reset_mid_refill();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Direct-mapped, write-through, no-write-allocate L1 controller placed directly upstream of `cache_block`, the 1K x 32-bit data array. It accepts word requests from a core, keeps the tag and valid arrays itself, and drives `cache_block`'s `index`/`we`/`din`. On a miss it performs a single-word refill or write-through over a simple memory handshake.

## Interface
- `NUM_OF_ENTRY`, 1024 (`_1K`): number of lines; must equal `2**ENTRY_WIDTH`.
- `ENTRY_WIDTH`, 10: index width.
- `DATA_WIDTH`, 32 (`_4B`): word width.
- `OFFSET_WIDTH`, 2: byte offset, ignored for lookup.
- `ADDR_WIDTH`, 32: address width. `TAG_WIDTH = ADDR_WIDTH - ENTRY_WIDTH - OFFSET_WIDTH` (20 by default), derived as a localparam.
- One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  core request present.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `req_ready`  out  1  controller can accept a request.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  DATA_WIDTH  read data; 0 for writes.
- `cb_index`  out  ENTRY_WIDTH  to `cache_block.index`.
- `cb_we`  out  1  to `cache_block.we`.
- `cb_din`  out  DATA_WIDTH  to `cache_block.din`.
- `cb_dout`  in  DATA_WIDTH  from `cache_block.dout`; combinational from `cb_index`.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  ADDR_WIDTH  word-aligned address, with offset bits = 0.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_ack`  in  1  memory done; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  DATA_WIDTH  refill data.

## Operation
- **Address split:** tag = `[ADDR_WIDTH-1 : ENTRY_WIDTH+OFFSET_WIDTH]`, index = `[ENTRY_WIDTH+OFFSET_WIDTH-1 : OFFSET_WIDTH]`.
- **Internal state:** registered `tag_arr[NUM_OF_ENTRY]` and `valid[NUM_OF_ENTRY]`. Hit = `valid[idx] && tag_arr[idx] == tag`.
- **IDLE:**
  - `req_ready = 1`.
  - On `req_valid`, latch address, we and wdata, then go to LOOKUP.
- **LOOKUP:** `cb_index` = latched index.
  - Read hit: latch `cb_dout` into `resp_rdata`, go to RESP.
  - Read miss: go to REFILL.
  - Write hit: `cb_we = 1` with `cb_din = wdata` for this one cycle, then go to WRITE_MEM.
  - Write miss: go to WRITE_MEM; the array and tags are untouched.
- **REFILL:**
  - Hold `mem_req = 1`, `mem_we = 0`.
  - In the `mem_ack` cycle: `cb_we = 1`, `cb_din = mem_rdata`, set `tag_arr[idx] = tag` and `valid[idx] = 1`, latch `mem_rdata` into `resp_rdata`, then go to RESP.
- **WRITE_MEM:**
  - Hold `mem_req = 1`, `mem_we = 1`, `mem_wdata = wdata`.
  - On `mem_ack`, set `resp_rdata = 0` and go to RESP.
- **RESP:** `resp_valid = 1` for one cycle, then go to IDLE.
- **Outputs:**
  - `cb_index` = latched index in every state except IDLE, where it tracks `req_addr`'s index.
  - `cb_we` is high only in the two cycles named above.
  - `cb_index` and `cb_din` are stable while `cb_we = 1`.
- **Memory handshake:** `mem_ack` is ignored when `mem_req = 0`.
- **Back-to-back access:** a request to the same index immediately after a refill hits.
- **Reset:** state = IDLE, all `valid` = 0, and every output is 0 (`req_ready` rises to 1 in the first cycle after reset). A reset during REFILL or WRITE_MEM abandons the access: no `cb_we`, no `resp_valid`, `mem_req` = 0 the next cycle.

## Timing
- Request accepted at cycle T (`req_valid && req_ready`).
- Read hit: LOOKUP at T+1, `resp_valid` at T+2, next accept at T+3.
- Read miss: REFILL from T+2. Ack at cycle A gives `resp_valid` at A+1; zero-wait memory (ack at T+2) gives `resp_valid` at T+3.
- Write: `cb_we` at T+1 on a hit, `mem_req` from T+2, `resp_valid` one cycle after `mem_ack`.
- `req_ready` is 0 from T+1 until the cycle after `resp_valid`, so there is one outstanding request at most.
- The core must take `resp_valid` unconditionally; there is no backpressure.

## Configuration
- **`CACHE_STATS_EN` defined:**
  - Adds outputs `hit_cnt` and `miss_cnt` (16 bits each).
  - Each is incremented once per request in LOOKUP, saturates at 16'hFFFF, and is cleared by `rst`.
- **`CACHE_STATS_EN` undefined:** the ports and counters are absent, and the behaviour is otherwise identical.

## Test plan
- **Reset:** `rst` for 2 cycles -> all outputs 0, `req_ready = 1` after release, and a read of 0x0000_0008 misses.
- **Read miss then hit:**
  - Read 0x0000_0008 with memory acking at +2 and returning 32'h0FF0 -> `cb_we` pulse at `cb_index = 2` with `cb_din = 32'h0FF0`, `resp_rdata = 32'h0FF0`.
  - Repeat the read -> hit, `resp_valid` at T+2, no `mem_req`.
- **Write hit:** preload index 2 as above, then write 32'hA5A5 to 0x0000_0008 -> `cb_we` at T+1 with `din = 32'hA5A5`, `mem_req`/`mem_we = 1` with `mem_addr = 0x0000_0008`, `resp_valid` after ack.
- **Write miss:** write to 0x0001_0008 (same index, different tag) -> no `cb_we`, one memory write, and a following read of 0x0000_0008 still hits.
- **Conflict:** read 0x0001_0008 after the index-2 fill -> miss, refill replaces the tag, and 0x0000_0008 then misses.
- **Reset mid-refill:** assert `rst` while REFILL waits for ack -> `mem_req = 0` the next cycle, no `resp_valid`, no `cb_we`. With `CACHE_STATS_EN` the counters read 0.
